misr: RTL
=========

# misr

Multiple-input signature register (MISR) for the LBIST response path. It is the receiving end of the LFSR pattern generator. It compacts one WIDTH-bit circuit-under-test response word per enabled cycle into a signature, over a programmable number of patterns. At the end of the run it compares the signature against a golden value and reports done/pass to the LBIST controller.

## Interface
- WIDTH, 21: signature and response width, in bits (must be ≥ 2).
- POLY, 21'h000005: feedback polynomial, Galois form; bit i = 1 XORs the feedback into stage i. Default is x^21+x^2+1.
- SEED, 0: signature value loaded on start.
- CNT_W, 16: width of the pattern counter and of n_pat.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse that begins a run; sampled only in IDLE or DONE.
- en  in  1  compaction enable; while low in RUN, signature and counter hold.
- n_pat  in  CNT_W  number of response words to compact; sampled on the start edge.
- resp  in  WIDTH  response word from the CUT scan outputs.
- golden  in  WIDTH  expected signature; sampled on the edge that enters DONE.
- sig  out  WIDTH  current signature register.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  compare result; valid while done = 1.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset, asynchronous at any time including mid-run:
  - state goes to IDLE.
  - sig = SEED, counter = 0, stored n_pat = 0.
  - busy = 0, done = 0, pass = 0.
- Compaction function:
  - fb = sig[WIDTH-1].
  - next = {sig[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0) ^ resp.
- IDLE or DONE, start = 1:
  - sig ← SEED, counter ← 0, n_pat latched.
  - done ← 0, pass ← 0.
  - If n_pat = 0: go directly to DONE, with pass ← (SEED == golden).
  - Otherwise: go to RUN.
- RUN, en = 1:
  - sig ← next, counter ← counter + 1.
  - If counter == n_pat − 1: go to DONE, with pass ← (next == golden).
- RUN, en = 0: all state holds.
- start is ignored in RUN; a run cannot be aborted except by rst_n.
- DONE: sig, pass and done hold until the next start.
- Counter arithmetic is unsigned CNT_W-bit. n_pat = 2^CNT_W − 1 is the maximum run length; the counter never wraps within a run.
- resp is don't-care outside RUN, and in RUN while en = 0.

## Timing
- Start edge E0: busy = 1 and sig = SEED are visible after E0.
- Each enabled edge compacts the resp presented before that edge. Latency from resp to sig is 1 cycle.
- With en held high: the k-th response is sampled at edge Ek, and done rises after edge E(n_pat). busy falls on the same edge.
- Each en-low cycle in RUN delays done by exactly 1 cycle.
- n_pat = 0: done = 1 after E0, and busy never asserts.
- start in DONE: done and pass clear after that edge.

## Test plan
All scenarios use WIDTH=4, POLY=4'b0011, SEED=0 unless stated otherwise.
- Reset: rst_n low, then high.
  - Required: sig=0, busy=0, done=0, pass=0.
  - Then assert rst_n low during RUN. Required: immediate IDLE, with sig=0 and busy=0 without waiting for a clock edge.
- Short runs, resp=4'h5 every cycle, en=1:
  - n_pat=1: sig=5.
  - n_pat=2: sig=F.
  - n_pat=3: sig=8; with golden=8, done=1 and pass=1 exactly 3 cycles after the start edge.
- Failing compare: n_pat=3, resp=5, golden=4'h9 → done=1, pass=0, sig=8.
- Enable gating: n_pat=3 with en low for 2 cycles mid-run → sig=8 still; done arrives 5 cycles after the start edge; sig is stable while en=0.
- Boundaries:
  - n_pat=0, golden=0 → done=1 and pass=1 one cycle after start; busy stays 0.
  - start pulsed during RUN → ignored; the result matches the uninterrupted run.
  - A second start from DONE → done clears and the run restarts from SEED.
- Default parameters: n_pat=1000 random resp with en=1 → sig matches the reference model; pass=1 when golden is set to the model value.

Source files
------------

// File: rtl/misr.sv
`default_nettype none
// ============================================================================
// Module   : misr
// Purpose  : Multiple-input signature register for the LBIST response path.
//            Compacts one WIDTH-bit response word per enabled cycle into a
//            Galois-form signature over n_pat patterns, then compares the
//            result against a golden value and reports done/pass.
// Ports    : clk     - system clock, rising edge
//            rst_n   - asynchronous active-low reset
//            start   - single-cycle run start (honoured in IDLE/DONE only)
//            en      - compaction enable; signature/counter hold when low
//            n_pat   - number of response words, latched on start
//            resp    - response word from the CUT scan outputs
//            golden  - expected signature, sampled on the edge entering DONE
//            sig     - current signature register
//            busy    - high while running
//            done    - high once the run has finished
//            pass    - compare result, valid while done is high
// Revision : 1.0 - initial release
// ============================================================================
module misr #(
  parameter int               WIDTH = 21,
  parameter logic [WIDTH-1:0] POLY  = 21'h000005,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [CNT_W-1:0] n_pat,
  input  logic [WIDTH-1:0] resp,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sig,   w_sig_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0] r_npat,  w_npat_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_pass,  w_pass_nxt;

  logic [WIDTH-1:0] w_compact;
  logic             w_last;

  // Galois step: shift left, fold the outgoing MSB back through POLY,
  // then mix in the response word.
  assign w_compact = {r_sig[WIDTH-2:0], 1'b0}
                   ^ (r_sig[WIDTH-1] ? POLY : '0)
                   ^ resp;

  // RUN is only entered with a non-zero n_pat, so n_pat-1 never underflows
  // while this is used.
  assign w_last = (r_cnt == (r_npat - c_cnt_one));

  always_comb begin
    w_state_nxt = r_state;
    w_sig_nxt   = r_sig;
    w_cnt_nxt   = r_cnt;
    w_npat_nxt  = r_npat;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_sig_nxt  = SEED;
          w_cnt_nxt  = c_cnt_zero;
          w_npat_nxt = n_pat;
          w_done_nxt = 1'b0;
          w_pass_nxt = 1'b0;
          if (n_pat == c_cnt_zero) begin
            // Empty run: the seed itself is the signature.
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (SEED == golden);
          end else begin
            w_state_nxt = S_RUN;
            w_busy_nxt  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (en) begin
          w_sig_nxt = w_compact;
          w_cnt_nxt = r_cnt + c_cnt_one;
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_compact == golden);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= c_cnt_zero;
      r_npat  <= c_cnt_zero;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_npat  <= w_npat_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign sig  = r_sig;
  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;

endmodule
`default_nettype wire
